// File: rtl/event_pending_capture.sv
// event_pending_capture: sticky capture of N event lines, presented one at a
// time as a registered one-hot word under a valid/ack handshake. Bit N-1 has
// the highest priority; repeated events on a pending line set a sticky flag.
module event_pending_capture #(
  parameter int unsigned N           = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE        = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] ev_in,
  input  logic         out_ack,
  input  logic         ovf_clr,
  output logic         out_valid,
  output logic [N-1:0] out_onehot,
  output logic [N-1:0] pending,
  output logic [N-1:0] ovf_flags
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  logic [N-1:0] ev_s;
  logic [N-1:0] ev_prev;
  logic [N-1:0] det;
  logic [N-1:0] clr;
  logic [N-1:0] avail;
  logic [N-1:0] sel;

  state_t       state_q;
  state_t       state_d;
  logic [N-1:0] onehot_d;
  logic         valid_d;

  // Input synchronizer chain (bypassed when SYNC_STAGES is 0)
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign ev_s = ev_in;
    end else begin : g_sync
      logic [N-1:0] sync_q [SYNC_STAGES];

      // Shift raw lines through the synchronizer flops
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= ev_in;
          for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end

      assign ev_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Previous synchronized value for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ev_prev <= '0;
    else     ev_prev <= ev_s;
  end

  // ev_prev resets low, so a line already high at reset release reads as one edge
  assign det   = EDGE ? (ev_s & ~ev_prev) : ev_s;
  assign clr   = (out_valid && out_ack) ? out_onehot : '0;
  assign avail = pending & ~clr;

  // Highest-priority selectable line; only registered pending is eligible
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (avail[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
  end

  // Sticky pending and overflow bits; a new event beats its own ack, ovf_clr beats a new overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      ovf_flags <= '0;
    end else begin
      pending   <= det | (pending & ~clr);
      ovf_flags <= ovf_clr ? '0 : (ovf_flags | (det & pending & ~clr));
    end
  end

  // FSM state and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      out_valid  <= 1'b0;
      out_onehot <= '0;
    end else begin
      state_q    <= state_d;
      out_valid  <= valid_d;
      out_onehot <= onehot_d;
    end
  end

  // Next state: hold the presented word until acked, then reload back-to-back or go idle
  always_comb begin
    state_d  = state_q;
    valid_d  = out_valid;
    onehot_d = out_onehot;
    case (state_q)
      IDLE: begin
        valid_d  = 1'b0;
        onehot_d = '0;
        if (|pending) begin
          onehot_d = sel;
          valid_d  = 1'b1;
          state_d  = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ack) begin
          if (|avail) begin
            onehot_d = sel;
            valid_d  = 1'b1;
          end else begin
            onehot_d = '0;
            valid_d  = 1'b0;
            state_d  = IDLE;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        valid_d  = 1'b0;
        onehot_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_event_pending_capture.sv
// Directed bench for event_pending_capture: edge-detect instance for the main
// scenarios plus a level-detect instance for the repeating-event case.
module tb_event_pending_capture;

  logic       clk;
  logic       rst;
  logic [7:0] ev;
  logic       ack;
  logic       oclr;
  logic       valid;
  logic [7:0] onehot;
  logic [7:0] pend;
  logic [7:0] ovf;

  logic [7:0] ev_l;
  logic       ack_l;
  logic       oclr_l;
  logic       valid_l;
  logic [7:0] onehot_l;
  logic [7:0] pend_l;
  logic [7:0] ovf_l;

  int vectors;
  int miscompares;

  event_pending_capture #(.N(8), .SYNC_STAGES(2), .EDGE(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .ev_in      (ev),
    .out_ack    (ack),
    .ovf_clr    (oclr),
    .out_valid  (valid),
    .out_onehot (onehot),
    .pending    (pend),
    .ovf_flags  (ovf)
  );

  event_pending_capture #(.N(8), .SYNC_STAGES(2), .EDGE(1'b0)) dut_lvl (
    .clk        (clk),
    .rst        (rst),
    .ev_in      (ev_l),
    .out_ack    (ack_l),
    .ovf_clr    (oclr_l),
    .out_valid  (valid_l),
    .out_onehot (onehot_l),
    .pending    (pend_l),
    .ovf_flags  (ovf_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 8x3 encoder view of the one-hot word
  function automatic logic [2:0] enc(input logic [7:0] oh);
    logic [2:0] y;
    y = 3'd0;
    for (int i = 0; i < 8; i++) if (oh[i]) y = 3'(i);
    return y;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic inv(input string tag, input logic v, input logic [7:0] oh);
    vectors++;
    assert ((v ? $onehot(oh) : (oh == 8'h00)) === 1'b1) else begin
      miscompares++;
      $error("FAIL %s: observed valid=%b onehot=%h expected one-hot when valid, zero otherwise", tag, v, oh);
    end
  endtask

  // Advance one rising edge and sample just after it
  task automatic step();
    @(posedge clk);
    #1;
    inv("inv_edge", valid, onehot);
    inv("inv_level", valid_l, onehot_l);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; ev = '0; ack = 1'b0; oclr = 1'b0;
    ev_l = '0; ack_l = 1'b0; oclr_l = 1'b0;
    step(); step();
    chk("rst_valid",   8'(valid), 8'h00);
    chk("rst_onehot",  onehot,    8'h00);
    chk("rst_pending", pend,      8'h00);
    chk("rst_ovf",     ovf,       8'h00);
    #2 rst = 1'b0;

    // 1: single pulse on line 2, latency and ack
    ev = 8'h04; step();
    ev = 8'h00; step();
    chk("t1_pend_e1",  pend,      8'h00);
    step();
    chk("t1_pend_e2",  pend,      8'h04);
    chk("t1_valid_e2", 8'(valid), 8'h00);
    step();
    chk("t1_valid_e3", 8'(valid), 8'h01);
    chk("t1_onehot_e3", onehot,   8'h04);
    ack = 1'b1; step(); ack = 1'b0;
    chk("t1_valid_ack", 8'(valid), 8'h00);
    chk("t1_pend_ack",  pend,      8'h00);
    chk("t1_onehot_ack", onehot,   8'h00);

    // 2: 8'hAA burst drained back-to-back with ack held
    ev = 8'hAA; ack = 1'b1; step();
    ev = 8'h00; step(); step();
    chk("t2_pend",     pend,      8'hAA);
    chk("t2_idle_ack", 8'(valid), 8'h00);
    step();
    chk("t2_oh7", onehot, 8'h80); chk("t2_y7", 8'(enc(onehot)), 8'd7);
    step();
    chk("t2_oh5", onehot, 8'h20); chk("t2_y5", 8'(enc(onehot)), 8'd5);
    step();
    chk("t2_oh3", onehot, 8'h08); chk("t2_y3", 8'(enc(onehot)), 8'd3);
    step();
    chk("t2_oh1", onehot, 8'h02); chk("t2_y1", 8'(enc(onehot)), 8'd1);
    step();
    chk("t2_done_valid", 8'(valid), 8'h00);
    chk("t2_done_pend",  pend,      8'h00);
    ack = 1'b0;

    // 3: no preemption by a later higher-priority event
    ev = 8'h02; step();
    ev = 8'h00; step(); step(); step();
    chk("t3_oh_first", onehot, 8'h02);
    ev = 8'h80; step();
    chk("t3_hold_a", onehot, 8'h02);
    step();
    chk("t3_hold_b", onehot, 8'h02);
    step();
    chk("t3_hold_c", onehot, 8'h02);
    chk("t3_pend",   pend,   8'h82);
    ev = 8'h00; step();
    chk("t3_hold_d", onehot, 8'h02);
    ack = 1'b1; step(); ack = 1'b0;
    chk("t3_next",      onehot, 8'h80);
    chk("t3_pend_next", pend,   8'h80);
    step();
    chk("t3_next_hold", onehot, 8'h80);
    ack = 1'b1; step(); ack = 1'b0;
    chk("t3_done_valid", 8'(valid), 8'h00);
    chk("t3_done_pend",  pend,      8'h00);

    // 4: overflow on a pending line, then ovf_clr
    ev = 8'h08; step();
    ev = 8'h00; step(); step(); step();
    chk("t4_oh",      onehot, 8'h08);
    chk("t4_ovf_pre", ovf,    8'h00);
    ev = 8'h08; step();
    ev = 8'h00; step();
    chk("t4_ovf_wait", ovf, 8'h00);
    step();
    chk("t4_ovf_set",  ovf,  8'h08);
    chk("t4_pend_set", pend, 8'h08);
    oclr = 1'b1; step(); oclr = 1'b0;
    chk("t4_ovf_clr",  ovf,    8'h00);
    chk("t4_pend_clr", pend,   8'h08);
    chk("t4_oh_clr",   onehot, 8'h08);
    ack = 1'b1; step(); ack = 1'b0;
    chk("t4_done_valid", 8'(valid), 8'h00);

    // 5: new edge on line 5 in the same cycle as its ack
    ev = 8'h20; step();
    ev = 8'h00; step(); step(); step();
    chk("t5_oh", onehot, 8'h20);
    ev = 8'h20; step();
    ev = 8'h00; step();
    ack = 1'b1; step(); ack = 1'b0;
    chk("t5_ovf",   ovf,       8'h00);
    chk("t5_pend",  pend,      8'h20);
    chk("t5_valid", 8'(valid), 8'h00);
    step();
    chk("t5_again_valid", 8'(valid), 8'h01);
    chk("t5_again_oh",    onehot,    8'h20);
    ack = 1'b1; step(); ack = 1'b0;
    chk("t5_done_pend", pend, 8'h00);

    // 6a: async reset while presenting with 3 lines pending
    ev = 8'h92; step();
    ev = 8'h00; step(); step(); step();
    chk("t6_oh",   onehot, 8'h80);
    chk("t6_pend", pend,   8'h92);
    rst = 1'b1; #1;
    chk("t6_rst_valid", 8'(valid), 8'h00);
    chk("t6_rst_oh",    onehot,    8'h00);
    chk("t6_rst_pend",  pend,      8'h00);
    chk("t6_rst_ovf",   ovf,       8'h00);
    #2 rst = 1'b0;
    step();
    chk("t6_post_valid", 8'(valid), 8'h00);
    chk("t6_post_pend",  pend,      8'h00);

    // 6b: level detect, line 0 held high, re-presented after every ack
    ev_l = 8'h01; ack_l = 1'b1;
    step(); step(); step();
    chk("t6l_pend",  pend_l,      8'h01);
    chk("t6l_valid", 8'(valid_l), 8'h00);
    step();
    chk("t6l_valid_1", 8'(valid_l), 8'h01);
    chk("t6l_oh_1",    onehot_l,    8'h01);
    chk("t6l_ovf",     ovf_l,       8'h01);
    step();
    chk("t6l_valid_2", 8'(valid_l), 8'h00);
    chk("t6l_pend_2",  pend_l,      8'h01);
    step();
    chk("t6l_valid_3", 8'(valid_l), 8'h01);
    chk("t6l_oh_3",    onehot_l,    8'h01);
    step();
    chk("t6l_valid_4", 8'(valid_l), 8'h00);
    ev_l = 8'h00; ack_l = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
